// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART ASCII command decoder: character codes,
// decoder state and byte classes.
package uart_cmd_pkg;

  localparam logic [7:0] CH_R_U = 8'h52;
  localparam logic [7:0] CH_R_L = 8'h72;
  localparam logic [7:0] CH_C_U = 8'h43;
  localparam logic [7:0] CH_C_L = 8'h63;
  localparam logic [7:0] CH_M_U = 8'h4D;
  localparam logic [7:0] CH_M_L = 8'h6D;
  localparam logic [7:0] CH_S_U = 8'h53;
  localparam logic [7:0] CH_S_L = 8'h73;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;

  typedef enum logic {IDLE, SET_DIG} state_e;

  typedef enum logic [2:0] {
    CMD_R, CMD_C, CMD_M, CMD_S, DIGIT, TERM, WS, OTHER
  } cls_e;

endpackage

// File: rtl/uart_ascii_class.sv
// Combinational byte classifier: folds lower-case letters to upper case and
// maps the byte to a command/digit/terminator class plus its digit value.
module uart_ascii_class
  import uart_cmd_pkg::*;
(
  input  logic [7:0] byte_in,
  output cls_e       cls,
  output logic [3:0] digit
);

  logic [7:0] folded;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    cls    = OTHER;
    digit  = byte_in[3:0];
    folded = byte_in;
    if (byte_in >= 8'h61 && byte_in <= 8'h7A) folded = byte_in & 8'hDF;
    case (folded)
      CH_R_U:        cls = CMD_R;
      CH_C_U:        cls = CMD_C;
      CH_M_U:        cls = CMD_M;
      CH_S_U:        cls = CMD_S;
      CH_CR, CH_LF:  cls = TERM;
      CH_SP:         cls = WS;
      default: begin
        if (byte_in >= CH_0 && byte_in <= CH_9) cls = DIGIT;
      end
    endcase
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder for the counter/FND datapath: R/C/M pulses and an
// "S<digits><CR|LF>" preset command with inter-byte timeout.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int MAX_DIGITS  = 4,
  parameter int VAL_W       = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic             o_run_toggle,
  output logic             o_clear,
  output logic             o_mode_toggle,
  output logic             o_set_valid,
  output logic [VAL_W-1:0] o_set_value,
  output logic             o_err,
  output logic             o_busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DIG_MAX  = CNT_W'(MAX_DIGITS);

  cls_e       cls;
  logic [3:0] digit;

  state_e           state, state_d;
  logic [VAL_W-1:0] acc, acc_d, value_q, value_d;
  logic [CNT_W-1:0] ndig, ndig_d;
  logic [TMO_W-1:0] tmo, tmo_d;
  logic run_d, clr_d, mode_d, setv_d, err_d;

  uart_ascii_class u_class (
    .byte_in (rx_data),
    .cls     (cls),
    .digit   (digit)
  );

  always_comb begin
    state_d = state;
    acc_d   = acc;
    ndig_d  = ndig;
    tmo_d   = tmo;
    value_d = value_q;
    run_d   = 1'b0;
    clr_d   = 1'b0;
    mode_d  = 1'b0;
    setv_d  = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done) begin
          case (cls)
            CMD_R: run_d  = 1'b1;
            CMD_C: clr_d  = 1'b1;
            CMD_M: mode_d = 1'b1;
            CMD_S: begin
              state_d = SET_DIG;
              acc_d   = '0;
              ndig_d  = '0;
            end
            TERM, WS: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      SET_DIG: begin
        // A byte landing in the expiry cycle wins over the timeout.
        if (rx_done) begin
          tmo_d = '0;
          case (cls)
            DIGIT: begin
              if (ndig >= DIG_MAX) begin
                err_d   = 1'b1;
                state_d = IDLE;
              end else begin
                acc_d  = (acc << 3) + (acc << 1) + VAL_W'(digit);
                ndig_d = ndig + CNT_W'(1);
              end
            end
            TERM: begin
              if (ndig != '0) begin
                value_d = acc;
                setv_d  = 1'b1;
              end else begin
                err_d = 1'b1;
              end
              state_d = IDLE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          endcase
        end else if (tmo == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) tmo_d = '0;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      ndig          <= '0;
      tmo           <= '0;
      value_q       <= '0;
      o_run_toggle  <= 1'b0;
      o_clear       <= 1'b0;
      o_mode_toggle <= 1'b0;
      o_set_valid   <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      state         <= state_d;
      acc           <= acc_d;
      ndig          <= ndig_d;
      tmo           <= tmo_d;
      value_q       <= value_d;
      o_run_toggle  <= run_d;
      o_clear       <= clr_d;
      o_mode_toggle <= mode_d;
      o_set_valid   <= setv_d;
      o_err         <= err_d;
    end
  end

  assign o_set_value = value_q;
  assign o_busy      = (state == SET_DIG);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: a byte-level command model queues
// expected pulses, an independent monitor compares them as the DUT emits them.
module tb_uart_cmd_decoder;

  localparam int TIMEOUT_CYC = 50;
  localparam int MAX_DIGITS  = 4;
  localparam int VAL_W       = 14;

  typedef enum int {K_NONE, K_RUN, K_CLR, K_MODE, K_SET, K_ERR} kind_e;
  typedef struct {
    kind_e kind;
    int    value;
    int    due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       rx_data = '0;
  logic             rx_done = 1'b0;
  logic             o_run_toggle, o_clear, o_mode_toggle, o_set_valid, o_err, o_busy;
  logic [VAL_W-1:0] o_set_value;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  bit   busy_at[int];

  // Reference model state
  bit m_busy = 0;
  int m_ndig = 0;
  int m_acc = 0;
  int m_idle = 0;

  uart_cmd_decoder #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_DIGITS  (MAX_DIGITS),
    .VAL_W       (VAL_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .o_run_toggle  (o_run_toggle),
    .o_clear       (o_clear),
    .o_mode_toggle (o_mode_toggle),
    .o_set_valid   (o_set_valid),
    .o_set_value   (o_set_value),
    .o_err         (o_err),
    .o_busy        (o_busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic expect_pulse(input kind_e k, input int v);
    exp_t e;
    e.kind  = k;
    e.value = v;
    e.due   = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Command-level model, evaluated once per cycle with that cycle's input.
  task automatic model(input bit v, input logic [7:0] b);
    logic [7:0] u;
    bit is_dig, is_term;
    u = b;
    if (u >= "a" && u <= "z") u = u - 8'd32;
    is_dig  = (b >= "0" && b <= "9");
    is_term = (b == 8'h0D || b == 8'h0A);
    if (!m_busy) begin
      if (v) begin
        if (u == "R")      expect_pulse(K_RUN, 0);
        else if (u == "C") expect_pulse(K_CLR, 0);
        else if (u == "M") expect_pulse(K_MODE, 0);
        else if (u == "S") begin
          m_busy = 1; m_ndig = 0; m_acc = 0; m_idle = 0;
        end
        else if (!(is_term || b == 8'h20)) expect_pulse(K_ERR, 0);
      end
    end else if (v) begin
      m_idle = 0;
      if (is_dig && m_ndig < MAX_DIGITS) begin
        m_acc  = m_acc * 10 + int'(b - 8'h30);
        m_ndig = m_ndig + 1;
      end else if (is_term && m_ndig > 0) begin
        expect_pulse(K_SET, m_acc);
        m_busy = 0;
      end else begin
        expect_pulse(K_ERR, 0);
        m_busy = 0;
      end
    end else begin
      m_idle = m_idle + 1;
      if (m_idle == TIMEOUT_CYC) begin
        expect_pulse(K_ERR, 0);
        m_busy = 0;
      end
    end
    busy_at[cyc + 1] = m_busy;
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_done = v;
    rx_data = v ? b : 8'($urandom);
    model(v, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    rx_done = 1'b0;
    busy_at[cyc + 1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy_at[cyc + 1] = 1'b0;
    m_busy = 0; m_ndig = 0; m_acc = 0; m_idle = 0;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_run_toggle", o_run_toggle, 0);
    check("rst_clear", o_clear, 0);
    check("rst_mode_toggle", o_mode_toggle, 0);
    check("rst_set_valid", o_set_valid, 0);
    check("rst_err", o_err, 0);
    check("rst_busy", o_busy, 0);
    check("rst_set_value", o_set_value, 0);
  endtask

  // Monitor: decoupled from stimulus, pops an expectation per observed pulse.
  always @(negedge clk) begin : monitor
    int    n;
    kind_e k;
    exp_t  e;
    n = int'(o_run_toggle) + int'(o_clear) + int'(o_mode_toggle) + int'(o_set_valid) + int'(o_err);
    if (busy_at.exists(cyc)) begin
      check("busy", o_busy, busy_at[cyc]);
      busy_at.delete(cyc);
    end
    if (n > 0) begin
      check("one_pulse_per_cycle", n, 1);
      if (o_run_toggle)       k = K_RUN;
      else if (o_clear)       k = K_CLR;
      else if (o_mode_toggle) k = K_MODE;
      else if (o_set_valid)   k = K_SET;
      else                    k = K_ERR;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_kind", k, K_NONE);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", k, e.kind);
        check("pulse_cycle", cyc, e.due);
        if (e.kind == K_SET) check("set_value", o_set_value, e.value);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      check("missing_pulse_kind", K_NONE, e.kind);
    end
  end

  initial begin
    string alpha;
    alpha = "RrCcMmSs0123456789\r\n xQ5\r7";

    do_reset();
    check_reset_state();

    // Single commands, spaced apart
    step(1'b1, "R"); idle(20);
    step(1'b1, "c"); idle(20);
    step(1'b1, "M"); idle(20);

    // Presets and their edges
    send("S1234\r"); idle(5);
    @(negedge clk) check("hold_1234", o_set_value, 1234);
    send("s0\n"); idle(5);
    @(negedge clk) check("hold_0", o_set_value, 0);
    send("S9999\r"); idle(5);
    @(negedge clk) check("hold_9999", o_set_value, 9999);
    send("S12345\r"); idle(5);
    @(negedge clk) check("unchanged_after_overflow", o_set_value, 9999);

    // Malformed input
    send("S\r"); idle(3);
    send("S12x"); idle(3);
    send("Q"); idle(3);
    send("\r\n "); idle(3);

    // Timeout expiry, then a digit landing exactly in the expiry cycle
    send("S12"); idle(60);
    send("S1"); idle(TIMEOUT_CYC - 1); send("7\r"); idle(3);
    @(negedge clk) check("hold_17", o_set_value, 17);

    // Reset mid-command, then back-to-back commands
    send("S56");
    do_reset();
    check_reset_state();
    step(1'b1, "R");
    step(1'b1, "C");
    idle(5);

    // Randomised byte stream with random gaps, occasionally long enough to time out
    for (int i = 0; i < 400; i++) begin
      step(1'b1, alpha[$urandom_range(0, alpha.len() - 1)]);
      if ($urandom_range(0, 39) == 0) idle(TIMEOUT_CYC + 5);
      else idle($urandom_range(0, 3));
    end

    idle(TIMEOUT_CYC + 10);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
